// File: rtl/mc_acc_pkg.sv
// mc_acc_pkg
// Shared defaults and helpers for the multi-channel accumulator datapath.
// The sat_max/sat_min helpers return the saturation limits of a signed
// number of the given width. The result sits in the low bits of a 64-bit
// vector, and callers truncate it to their own width.
package mc_acc_pkg;

  localparam int IN_WIDTH_DEF  = 14;
  localparam int ACC_WIDTH_DEF = 18;
  localparam int CHANNELS_DEF  = 4;
  localparam bit SATURATE_DEF  = 1'b1;
  localparam int MAX_WIDTH     = 64;

  // Largest positive value: 0 followed by all ones.
  function automatic logic [MAX_WIDTH-1:0] sat_max(input int width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < width - 1; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Most negative value: 1 followed by all zeros.
  function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

  // Width of a channel index. Never less than one bit.
  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/sat_adder.sv
// sat_adder
// Combinational signed adder with optional clamping. The node-compare stage
// also uses it.
// Ports:
//   a, b      in   ACC_WIDTH  signed summands
//   saturate  in   1          1 = clamp on overflow, 0 = two's-complement wrap
//   y         out  ACC_WIDTH  signed result
//   ovf       out  1          true sum does not fit in ACC_WIDTH bits
module sat_adder
  import mc_acc_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic [ACC_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0] b,
  input  logic                 saturate,
  output logic [ACC_WIDTH-1:0] y,
  output logic                 ovf
);

  localparam logic [ACC_WIDTH-1:0] POS_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] NEG_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));

  logic [ACC_WIDTH:0] sum;

  // Add one guard bit. If the guard bit disagrees with the result MSB, the
  // sum overflowed. The guard bit then gives the true sign, which selects
  // the clamp direction.
  always_comb begin
    sum = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    y   = sum[ACC_WIDTH-1:0];
    if (ovf && saturate) y = sum[ACC_WIDTH] ? NEG_MIN : POS_MAX;
  end

endmodule

// File: rtl/mc_accumulator.sv
// mc_accumulator
// Signed accumulator with several channels for the decision-tree datapath.
// Each channel keeps an accumulator and a sticky overflow flag. A beat
// marked last sends that channel's result to a single-entry valid/ready
// output register and clears the channel.
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   in_valid/in_ready  input handshake (in_ready = !out_valid || out_ready)
//   in_ch              target channel; in_ch >= CHANNELS is accepted and dropped
//   in_load            left summand = in_init instead of stored acc; clears sticky
//   in_add             right summand = sign-extended in_a (else zero)
//   in_last            emit result and clear the channel
//   in_init, in_a      signed load value / signed addend
//   out_valid/out_ready output handshake
//   out_ch, out_y, out_ovf  channel, result and sticky overflow of the held result
module mc_accumulator
  import mc_acc_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int CHANNELS  = CHANNELS_DEF,
  parameter bit SATURATE  = SATURATE_DEF,
  localparam int CH_W     = ch_width(CHANNELS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH_W-1:0]      in_ch,
  input  logic                 in_load,
  input  logic                 in_add,
  input  logic                 in_last,
  input  logic [ACC_WIDTH-1:0] in_init,
  input  logic [IN_WIDTH-1:0]  in_a,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH_W-1:0]      out_ch,
  output logic [ACC_WIDTH-1:0] out_y,
  output logic                 out_ovf
);

  logic [ACC_WIDTH-1:0] acc [CHANNELS];
  logic [CHANNELS-1:0]  sticky;

  logic                 ch_ok;
  logic                 accept;
  logic                 accept_last;
  logic [ACC_WIDTH-1:0] acc_sel;
  logic                 sticky_sel;
  logic [ACC_WIDTH-1:0] left;
  logic [ACC_WIDTH-1:0] right;
  logic [ACC_WIDTH-1:0] result;
  logic                 ovf;
  logic                 new_sticky;

  // Select the channel by comparing against each legal index. This avoids
  // indexing the arrays with a value that may be out of range. When no
  // index matches, ch_ok stays low.
  always_comb begin
    acc_sel    = '0;
    sticky_sel = 1'b0;
    ch_ok      = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_ch == CH_W'(i)) begin
        acc_sel    = acc[i];
        sticky_sel = sticky[i];
        ch_ok      = 1'b1;
      end
    end
  end

  // in_ready depends only on the output register, never on in_valid.
  // A beat for an out-of-range channel still completes the handshake, but
  // it changes no state.
  assign in_ready    = !out_valid || out_ready;
  assign accept      = in_valid && in_ready && ch_ok;
  assign accept_last = accept && in_last;

  assign left  = in_load ? in_init : acc_sel;
  assign right = in_add ? {{(ACC_WIDTH-IN_WIDTH){in_a[IN_WIDTH-1]}}, in_a} : '0;

  sat_adder #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_sat_adder (
    .a       (left),
    .b       (right),
    .saturate(SATURATE),
    .y       (result),
    .ovf     (ovf)
  );

  assign new_sticky = (in_load ? 1'b0 : sticky_sel) | ovf;

  // A last beat writes zero back, so the channel starts fresh on the next
  // beat. A new result may replace the held one in the same cycle it drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
      sticky    <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_ch    <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (in_ch == CH_W'(i)) begin
            acc[i]    <= in_last ? '0 : result;
            sticky[i] <= in_last ? 1'b0 : new_sticky;
          end
        end
      end
      if (accept_last) begin
        out_valid <= 1'b1;
        out_y     <= result;
        out_ch    <= in_ch;
        out_ovf   <= new_sticky;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mc_accumulator.sv
// tb_mc_accumulator
// Drives two instances from shared inputs. Instance a saturates and has
// four channels. Instance b wraps and has three channels, so in_ch = 3 is
// out of range for b. A directed vector table sets the expected outputs of
// both instances. A randomized phase compares both against an arithmetic
// reference model.
module tb_mc_accumulator;
  import mc_acc_pkg::*;

  localparam int IN_W  = 14;
  localparam int ACC_W = 18;
  localparam int CHW   = 2;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [CHW-1:0]   in_ch;
  logic             in_load;
  logic             in_add;
  logic             in_last;
  logic [ACC_W-1:0] in_init;
  logic [IN_W-1:0]  in_a;
  logic             out_ready;

  logic             in_ready_a, out_valid_a, out_ovf_a;
  logic [CHW-1:0]   out_ch_a;
  logic [ACC_W-1:0] out_y_a;
  logic             in_ready_b, out_valid_b, out_ovf_b;
  logic [CHW-1:0]   out_ch_b;
  logic [ACC_W-1:0] out_y_b;

  int checks;
  int failures;

  mc_accumulator #(
    .IN_WIDTH(IN_W), .ACC_WIDTH(ACC_W), .CHANNELS(4), .SATURATE(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_ch(in_ch), .in_load(in_load), .in_add(in_add), .in_last(in_last),
    .in_init(in_init), .in_a(in_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_ch(out_ch_a), .out_y(out_y_a), .out_ovf(out_ovf_a)
  );

  mc_accumulator #(
    .IN_WIDTH(IN_W), .ACC_WIDTH(ACC_W), .CHANNELS(3), .SATURATE(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_ch(in_ch), .in_load(in_load), .in_add(in_add), .in_last(in_last),
    .in_init(in_init), .in_a(in_a), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_ch(out_ch_b), .out_y(out_y_b), .out_ovf(out_ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, indexed by instance (0 = a, 1 = b).
  longint m_acc [2][4];
  bit     m_st  [2][4];
  bit     m_ov  [2];
  longint m_y   [2];
  int     m_ch  [2];
  bit     m_ovf [2];

  localparam longint LO = -(longint'(1) << (ACC_W - 1));
  localparam longint HI = (longint'(1) << (ACC_W - 1)) - 1;

  typedef struct {
    bit rst; bit v; int ch; bit ld; bit add; bit last; int init; int a; bit ordy;
    bit ev;   int ey;   int ech;   bit eovf;
    bit ev_b; int ey_b; int ech_b; bit eovf_b;
  } vec_t;

  vec_t vecs[24];

  task automatic check_value(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic model_step(input int k, input bit rst, input bit v, input int ch,
                            input bit ld, input bit add, input bit last,
                            input longint init, input longint a, input bit ordy);
    int     nch;
    bit     took_last;
    longint l, r, s, res;
    bit     o, st;
    nch = (k == 0) ? 4 : 3;
    took_last = 0;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_acc[k][i] = 0; m_st[k][i] = 0; end
      m_ov[k] = 0; m_y[k] = 0; m_ch[k] = 0; m_ovf[k] = 0;
      return;
    end
    if (v && (!m_ov[k] || ordy) && ch < nch) begin
      l = ld ? init : m_acc[k][ch];
      r = add ? a : 0;
      s = l + r;
      o = (s > HI) || (s < LO);
      if (!o) res = s;
      else if (k == 0) res = (s > HI) ? HI : LO;
      else res = (s > HI) ? s - (longint'(1) << ACC_W) : s + (longint'(1) << ACC_W);
      st = (ld ? 1'b0 : m_st[k][ch]) | o;
      if (last) begin
        m_y[k] = res; m_ch[k] = ch; m_ovf[k] = st; m_ov[k] = 1;
        m_acc[k][ch] = 0; m_st[k][ch] = 0;
        took_last = 1;
      end else begin
        m_acc[k][ch] = res; m_st[k][ch] = st;
      end
    end
    if (!took_last && ordy) m_ov[k] = 0;
  endtask

  task automatic compare_model(input int k, input bit ordy);
    if (k == 0) begin
      check_value("mdl_a_valid", out_valid_a, m_ov[0]);
      check_value("mdl_a_y", longint'($signed(out_y_a)), m_y[0]);
      check_value("mdl_a_ch", out_ch_a, m_ch[0]);
      check_value("mdl_a_ovf", out_ovf_a, m_ovf[0]);
      check_value("mdl_a_ready", in_ready_a, !m_ov[0] || ordy);
    end else begin
      check_value("mdl_b_valid", out_valid_b, m_ov[1]);
      check_value("mdl_b_y", longint'($signed(out_y_b)), m_y[1]);
      check_value("mdl_b_ch", out_ch_b, m_ch[1]);
      check_value("mdl_b_ovf", out_ovf_b, m_ovf[1]);
      check_value("mdl_b_ready", in_ready_b, !m_ov[1] || ordy);
    end
  endtask

  // One clock cycle: drive inputs, check the combinational in_ready, step
  // the model, cross the edge, then compare against the model.
  task automatic apply_stimulus(input bit rst, input bit v, input int ch, input bit ld,
                                input bit add, input bit last, input longint init,
                                input longint a, input bit ordy);
    reset = rst; in_valid = v; in_ch = CHW'(ch); in_load = ld; in_add = add;
    in_last = last; in_init = ACC_W'(init); in_a = IN_W'(a); out_ready = ordy;
    #1;
    if (!rst) begin
      check_value("pre_ready_a", in_ready_a, !m_ov[0] || ordy);
      check_value("pre_ready_b", in_ready_b, !m_ov[1] || ordy);
    end
    model_step(0, rst, v, ch, ld, add, last, init, a, ordy);
    model_step(1, rst, v, ch, ld, add, last, init, a, ordy);
    @(posedge clk);
    #1;
    compare_model(0, ordy);
    compare_model(1, ordy);
  endtask

  task automatic check_output(input int idx, input vec_t t);
    string p;
    p = $sformatf("vec%0d", idx);
    check_value({p, "_a_valid"}, out_valid_a, t.ev);
    check_value({p, "_a_y"}, longint'($signed(out_y_a)), t.ey);
    check_value({p, "_a_ch"}, out_ch_a, t.ech);
    check_value({p, "_a_ovf"}, out_ovf_a, t.eovf);
    check_value({p, "_a_ready"}, in_ready_a, !t.ev || t.ordy);
    check_value({p, "_b_valid"}, out_valid_b, t.ev_b);
    check_value({p, "_b_y"}, longint'($signed(out_y_b)), t.ey_b);
    check_value({p, "_b_ch"}, out_ch_b, t.ech_b);
    check_value({p, "_b_ovf"}, out_ovf_b, t.eovf_b);
    check_value({p, "_b_ready"}, in_ready_b, !t.ev_b || t.ordy);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; in_valid = 1'b0; in_ch = '0; in_load = 1'b0; in_add = 1'b0;
    in_last = 1'b0; in_init = '0; in_a = '0; out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin m_acc[k][i] = 0; m_st[k][i] = 0; end
      m_ov[k] = 0; m_y[k] = 0; m_ch[k] = 0; m_ovf[k] = 0;
    end

    //          rst v ch ld ad ls init     a   ordy  ev ey      ech eo  evb eyb      echb eob
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0,      0,    1,  0, 0,      0, 0,  0, 0,       0, 0};
    vecs[1]  = '{0, 1, 0, 1, 1, 0, 5,      3,    1,  0, 0,      0, 0,  0, 0,       0, 0};
    vecs[2]  = '{0, 1, 0, 0, 1, 0, 0,      -2,   1,  0, 0,      0, 0,  0, 0,       0, 0};
    vecs[3]  = '{0, 1, 0, 0, 1, 1, 0,      4,    1,  1, 10,     0, 0,  1, 10,      0, 0};
    vecs[4]  = '{0, 1, 0, 0, 0, 1, 0,      0,    1,  1, 0,      0, 0,  1, 0,       0, 0};
    vecs[5]  = '{0, 1, 1, 1, 0, 0, 131070, 0,    1,  0, 0,      0, 0,  0, 0,       0, 0};
    vecs[6]  = '{0, 1, 1, 0, 1, 1, 0,      5,    1,  1, 131071, 1, 1,  1, -131069, 1, 1};
    vecs[7]  = '{0, 1, 2, 1, 1, 0, 131071, 1,    1,  0, 131071, 1, 1,  0, -131069, 1, 1};
    vecs[8]  = '{0, 1, 2, 0, 1, 0, 0,      -100, 1,  0, 131071, 1, 1,  0, -131069, 1, 1};
    vecs[9]  = '{0, 1, 2, 1, 1, 1, 7,      0,    1,  1, 7,      2, 0,  1, 7,       2, 0};
    vecs[10] = '{0, 1, 1, 0, 1, 0, 0,      1,    1,  0, 7,      2, 0,  0, 7,       2, 0};
    vecs[11] = '{0, 1, 3, 0, 1, 0, 0,      10,   1,  0, 7,      2, 0,  0, 7,       2, 0};
    vecs[12] = '{0, 1, 1, 0, 1, 0, 0,      1,    1,  0, 7,      2, 0,  0, 7,       2, 0};
    vecs[13] = '{0, 1, 3, 0, 1, 1, 0,      10,   1,  1, 20,     3, 0,  0, 7,       2, 0};
    vecs[14] = '{0, 1, 1, 0, 1, 1, 0,      1,    1,  1, 3,      1, 0,  1, 3,       1, 0};
    vecs[15] = '{0, 1, 0, 1, 0, 1, 50,     0,    1,  1, 50,     0, 0,  1, 50,      0, 0};
    vecs[16] = '{0, 1, 0, 1, 0, 1, 99,     0,    0,  1, 50,     0, 0,  1, 50,      0, 0};
    vecs[17] = '{0, 0, 0, 0, 0, 0, 0,      0,    0,  1, 50,     0, 0,  1, 50,      0, 0};
    vecs[18] = '{0, 1, 1, 1, 0, 1, -20,    0,    1,  1, -20,    1, 0,  1, -20,     1, 0};
    vecs[19] = '{0, 0, 0, 0, 0, 0, 0,      0,    1,  0, -20,    1, 0,  0, -20,     1, 0};
    vecs[20] = '{0, 1, 0, 1, 0, 0, 33,     0,    1,  0, -20,    1, 0,  0, -20,     1, 0};
    vecs[21] = '{0, 1, 1, 1, 0, 1, 44,     0,    0,  1, 44,     1, 0,  1, 44,      1, 0};
    vecs[22] = '{1, 1, 0, 0, 1, 1, 0,      1,    0,  0, 0,      0, 0,  0, 0,       0, 0};
    vecs[23] = '{0, 1, 0, 0, 0, 1, 0,      0,    1,  1, 0,      0, 0,  1, 0,       0, 0};

    #2;
    for (int i = 0; i < 24; i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].v, vecs[i].ch, vecs[i].ld, vecs[i].add,
                     vecs[i].last, vecs[i].init, vecs[i].a, vecs[i].ordy);
      check_output(i, vecs[i]);
    end

    // Randomized traffic. Load values are biased toward the positive and
    // negative limits so that overflow and sticky behaviour appear often.
    for (int n = 0; n < 800; n++) begin
      bit     rst, v, ld, add, last, ordy;
      int     ch;
      longint init, a;
      rst  = ($urandom_range(0, 99) == 0);
      v    = ($urandom_range(0, 3) != 0);
      ch   = $urandom_range(0, 3);
      ld   = ($urandom_range(0, 3) == 0);
      add  = ($urandom_range(0, 4) != 0);
      last = ($urandom_range(0, 4) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 2))
        0:       init = HI - longint'($urandom_range(0, 9000));
        1:       init = LO + longint'($urandom_range(0, 9000));
        default: init = longint'($urandom_range(0, 262143)) - 131072;
      endcase
      a = longint'($urandom_range(0, 16383)) - 8192;
      apply_stimulus(rst, v, ch, ld, add, last, init, a, ordy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
